// File: rtl/burst_mem_pkg.sv
// Shared types, geometry constants and address helpers for the burst memory responder.
package burst_mem_pkg;

  localparam int PMEM_ADDR_W     = 32;
  localparam int PMEM_DATA_W     = 64;
  localparam int PMEM_BURST_LEN  = 4;
  localparam int PMEM_LINE_IDX_W = 8;
  localparam int LINE_OFS_W      = 5;
  localparam int BEAT_IDX_W      = $clog2(PMEM_BURST_LEN);

  typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_e;
  typedef enum logic {DIR_READ, DIR_WRITE} dir_e;

  // Upper address bits are dropped on purpose: lines alias modulo the array size.
  function automatic logic [PMEM_LINE_IDX_W-1:0] line_idx(input logic [PMEM_ADDR_W-1:0] addr);
    return PMEM_LINE_IDX_W'(addr >> LINE_OFS_W);
  endfunction

endpackage

// File: rtl/burst_mem_array.sv
// Word-addressed storage with one write port and one registered read port.
// The read register resets to zero so the beat output is defined out of reset.
module burst_mem_array #(
  parameter int WORD_IDX_W = 10,
  parameter int DATA_W     = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [WORD_IDX_W-1:0] waddr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic                  re_i,
  input  logic [WORD_IDX_W-1:0] raddr_i,
  output logic [DATA_W-1:0]     rdata_o
);

  logic [DATA_W-1:0] mem_q [2**WORD_IDX_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/burst_mem_responder.sv
// Memory-side responder for the 4-beat pmem burst interface, fixed-latency line reads/writes.
//   state | meaning
//   IDLE  | waiting for a request; backdoor preload allowed
//   WAIT  | latency countdown before the first beat
//   BURST | pmem_resp high, one beat per cycle
//   DONE  | burst finished, waiting for the initiator to drop its request
module burst_mem_responder
  import burst_mem_pkg::*;
#(
  parameter int ADDR_W     = PMEM_ADDR_W,
  parameter int DATA_W     = PMEM_DATA_W,
  parameter int BURST_LEN  = PMEM_BURST_LEN,
  parameter int LINE_IDX_W = PMEM_LINE_IDX_W,
  parameter int LATENCY    = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  pmem_read_i,
  input  logic                  pmem_write_i,
  input  logic [ADDR_W-1:0]     pmem_address_i,
  input  logic [DATA_W-1:0]     pmem_wdata_i,
  output logic [DATA_W-1:0]     pmem_rdata_o,
  output logic                  pmem_resp_o,
  input  logic                  init_we_i,
  input  logic [LINE_IDX_W+1:0] init_addr_i,
  input  logic [DATA_W-1:0]     init_data_i,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int WORD_IDX_W = LINE_IDX_W + BEAT_IDX_W;
  localparam int CNT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(BURST_LEN - 1);

  state_e                  state_q;
  dir_e                    dir_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [BEAT_IDX_W-1:0]   beat_q;
  logic [LINE_IDX_W-1:0]   line_q;
  logic                    resp_q;
  logic                    err_q;

  logic                    rd_req, wr_req, req_ok, misaligned;
  logic                    mem_we, mem_re;
  logic [WORD_IDX_W-1:0]   mem_waddr, mem_raddr;
  logic [DATA_W-1:0]       mem_wdata;

  assign rd_req     = pmem_read_i & ~pmem_write_i;
  assign wr_req     = pmem_write_i & ~pmem_read_i;
  assign req_ok     = (dir_q == DIR_READ) ? rd_req : wr_req;
  assign misaligned = |pmem_address_i[LINE_OFS_W-1:0];

  // Reads are issued one edge ahead so each beat lands in the read register with its strobe.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = init_addr_i;
    mem_wdata = init_data_i;
    mem_re    = 1'b0;
    mem_raddr = {line_q, {BEAT_IDX_W{1'b0}}};
    case (state_q)
      IDLE: mem_we = init_we_i;
      WAIT: mem_re = (dir_q == DIR_READ) && req_ok && (cnt_q == '0);
      BURST: begin
        if (dir_q == DIR_WRITE) begin
          mem_we    = req_ok;
          mem_waddr = {line_q, beat_q};
          mem_wdata = pmem_wdata_i;
        end else begin
          mem_re    = req_ok && (beat_q != LAST_BEAT);
          mem_raddr = {line_q, beat_q + BEAT_IDX_W'(1)};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      dir_q   <= DIR_READ;
      cnt_q   <= '0;
      beat_q  <= '0;
      line_q  <= '0;
      resp_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pmem_read_i && pmem_write_i) begin
            err_q <= 1'b1;
          end else if (pmem_read_i || pmem_write_i) begin
            state_q <= WAIT;
            dir_q   <= pmem_write_i ? DIR_WRITE : DIR_READ;
            line_q  <= line_idx(pmem_address_i);
            cnt_q   <= CNT_W'(LATENCY - 1);
            if (misaligned) err_q <= 1'b1;
          end
        end
        WAIT: begin
          if (!req_ok) begin
            state_q <= IDLE;
            err_q   <= 1'b1;
          end else if (cnt_q == '0) begin
            state_q <= BURST;
            beat_q  <= '0;
            resp_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        BURST: begin
          if (!req_ok) begin
            state_q <= IDLE;
            resp_q  <= 1'b0;
            err_q   <= 1'b1;
          end else if (beat_q == LAST_BEAT) begin
            state_q <= DONE;
            resp_q  <= 1'b0;
          end else begin
            beat_q <= beat_q + BEAT_IDX_W'(1);
          end
        end
        DONE: begin
          if (!pmem_read_i && !pmem_write_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (init_we_i && (state_q != IDLE)) err_q <= 1'b1;
    end
  end

  burst_mem_array #(
    .WORD_IDX_W (WORD_IDX_W),
    .DATA_W     (DATA_W)
  ) u_array (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .re_i    (mem_re),
    .raddr_i (mem_raddr),
    .rdata_o (pmem_rdata_o)
  );

  assign pmem_resp_o = resp_q;
  assign busy_o      = (state_q != IDLE);
  assign err_o       = err_q;

endmodule
